// File: rtl/fir_chain_pkg.sv
// Shared constants for the FIR chain blocks. Every sample width in the chain
// is derived from SAMPLE_W.
package fir_chain_pkg;

   localparam int SAMPLE_W           = 8;
   localparam int DECIM_DEFAULT      = 4;
   localparam int FIFO_DEPTH_DEFAULT = 4;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock show-ahead FIFO. The head entry is always presented on
// pop_data, and pop_data reads 0 while the FIFO is empty. A push into a full
// FIFO is accepted only when a pop happens on the same edge. Otherwise the
// push is ignored, and the parent detects that case as a drop.
module sync_fifo
   import fir_chain_pkg::*;
#(
   parameter int WIDTH = SAMPLE_W,
   parameter int DEPTH = FIFO_DEPTH_DEFAULT
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         pop_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [AW:0]      level_q, level_d;
   logic             do_push, do_pop;

   // Accept/reject decisions, next pointers (power-of-two wrap) and occupancy
   always_comb begin
      empty    = (level_q == '0);
      full     = (level_q == (AW+1)'(DEPTH));
      do_pop   = pop && !empty;
      do_push  = push && (!full || do_pop);
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      if (do_push) begin
         wr_ptr_d = wr_ptr_q + AW'(1);
      end
      if (do_pop) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
      end
      if (do_push && !do_pop) begin
         level_d = level_q + (AW+1)'(1);
      end else if (do_pop && !do_push) begin
         level_d = level_q - (AW+1)'(1);
      end
      level    = level_q;
      pop_data = empty ? '0 : mem_q[rd_ptr_q];
   end

   // Pointer and occupancy registers
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
      end
   end

   // Storage array. It is not reset, because empty masks the head entry.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem_q[wr_ptr_q] <= push_data;
      end
   end

endmodule

// File: rtl/fir_decimator.sv
// Decimates the FIR output stream by DECIM and queues the decimated samples
// in a small show-ahead FIFO.
// Build option FIR_DECIM_AVG_EN: when it is defined, each decimated sample is
// the truncated mean of its window. When it is undefined, each decimated
// sample is the last input of its window, and no accumulator exists.
module fir_decimator
   import fir_chain_pkg::*;
#(
   parameter int DECIM      = DECIM_DEFAULT,
   parameter int FIFO_DEPTH = FIFO_DEPTH_DEFAULT
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [SAMPLE_W-1:0]           in_data,
   input  logic                          in_valid,
   output logic [SAMPLE_W-1:0]           out_data,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [$clog2(FIFO_DEPTH):0]   level,
   output logic                          overflow
);

   localparam int PH_W = $clog2(DECIM);

   logic [PH_W-1:0]     phase_q, phase_d;
   logic                overflow_q, overflow_d;
   logic                last_phase, gen;
   logic [SAMPLE_W-1:0] sample;
   logic                fifo_full, fifo_empty;

   // Window bookkeeping. The phase moves only on accepted inputs, and the
   // input at the last phase closes the window. A push can be lost only
   // when the FIFO is full and the head is not leaving on the same edge.
   always_comb begin
      last_phase = (phase_q == PH_W'(DECIM - 1));
      gen        = in_valid && last_phase;
      phase_d    = in_valid ? phase_q + PH_W'(1) : phase_q;
      overflow_d = overflow_q | (gen & fifo_full & ~out_ready);
   end

   // Phase counter and sticky overflow flag
   always_ff @(posedge clk) begin
      if (rst) begin
         phase_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         phase_q    <= phase_d;
         overflow_q <= overflow_d;
      end
   end

`ifdef FIR_DECIM_AVG_EN
   localparam int ACC_W = SAMPLE_W + PH_W;

   logic [ACC_W-1:0] acc_q, acc_d, sum;

   // Window sum. Phase 0 reloads the accumulator instead of adding to it,
   // which avoids a separate clear cycle between windows.
   always_comb begin
      sum    = ((phase_q == '0) ? '0 : acc_q) + ACC_W'(in_data);
      acc_d  = in_valid ? sum : acc_q;
      sample = sum[PH_W +: SAMPLE_W];
   end

   // Accumulator register
   always_ff @(posedge clk) begin
      if (rst) begin
         acc_q <= '0;
      end else begin
         acc_q <= acc_d;
      end
   end
`else
   // Pick the closing sample of each window
   always_comb begin
      sample = in_data;
   end
`endif

   sync_fifo #(
      .WIDTH (SAMPLE_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (gen),
      .push_data (sample),
      .pop       (out_ready),
      .pop_data  (out_data),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .level     (level)
   );

   // Output status
   always_comb begin
      out_valid = ~fifo_empty;
      overflow  = overflow_q;
   end

endmodule

// File: tb/tb_fir_decimator.sv
// Directed testbench for fir_decimator with DECIM=4 and FIFO_DEPTH=4.
// The expected values follow the build option FIR_DECIM_AVG_EN.
module tb_fir_decimator;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [7:0] in_data = '0;
   logic       in_valid = 1'b0;
   logic [7:0] out_data;
   logic       out_valid;
   logic       out_ready = 1'b0;
   logic [2:0] level;
   logic       overflow;

   int checks = 0;
   int failures = 0;

   fir_decimator #(.DECIM(4), .FIFO_DEPTH(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .level     (level),
      .overflow  (overflow)
   );

   always #5 clk = ~clk;

   // Expected decimated sample for one window of four inputs
   function automatic int exp_win(input int a, input int b, input int c, input int d);
`ifdef FIR_DECIM_AVG_EN
      return (a + b + c + d) >> 2;
`else
      return d + 0 * (a + b + c);
`endif
   endfunction

   task automatic check(input string tag, input int got, input int exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end else begin
         $display("ok   %s: %0d", tag, got);
      end
   endtask

   // Advance one edge; outputs are then sampled 1 ns after the edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input int v);
      in_valid = 1'b1;
      in_data  = 8'(v);
      tick();
      in_valid = 1'b0;
   endtask

   task automatic idle();
      in_valid = 1'b0;
      tick();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   int gap_seq[7] = '{40, -1, -1, 30, -1, 20, 10};

   initial begin
      #2;
      // Reset state
      do_reset();
      check("rst_valid", int'(out_valid), 0);
      check("rst_level", int'(level), 0);
      check("rst_ovf", int'(overflow), 0);
      check("rst_data", int'(out_data), 0);

      // Eight continuous inputs with the sink always ready
      out_ready = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         send(i * 10);
         if (i == 4) check("cont_w0", int'(out_data), exp_win(10, 20, 30, 40));
         else if (i == 8) check("cont_w1", int'(out_data), exp_win(50, 60, 70, 80));
         else check($sformatf("cont_nv%0d", i), int'(out_valid), 0);
      end
      idle();
      check("cont_drain", int'(out_valid), 0);

      // Window values, including the all-ones window
      out_ready = 1'b0;
      send(10); send(20); send(30); send(41);
      check("win_a", int'(out_data), exp_win(10, 20, 30, 41));
      check("win_a_lvl", int'(level), 1);
      out_ready = 1'b1;
      idle();
      out_ready = 1'b0;
      for (int i = 0; i < 4; i++) send(255);
      check("win_ff", int'(out_data), exp_win(255, 255, 255, 255));
      out_ready = 1'b1;
      idle();
      check("win_ff_pop", int'(level), 0);

      // Gaps in in_valid: the phase must hold through them
      for (int i = 0; i < 7; i++) begin
         if (gap_seq[i] < 0) idle();
         else send(gap_seq[i]);
         if (i < 6) check($sformatf("gap_nv%0d", i), int'(out_valid), 0);
      end
      check("gap_out", int'(out_data), exp_win(40, 30, 20, 10));
      check("gap_lvl", int'(level), 1);
      idle();

      // Fill the FIFO with the sink stalled, then overflow it
      out_ready = 1'b0;
      for (int i = 1; i <= 20; i++) begin
         send(i);
         if (i == 16) begin
            check("ovf_lvl16", int'(level), 4);
            check("ovf_flag16", int'(overflow), 0);
         end
      end
      check("ovf_lvl20", int'(level), 4);
      check("ovf_flag20", int'(overflow), 1);
      out_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         check($sformatf("ovf_drain%0d", k), int'(out_data),
               exp_win(4*k + 1, 4*k + 2, 4*k + 3, 4*k + 4));
         idle();
      end
      check("ovf_empty", int'(out_valid), 0);
      check("ovf_sticky", int'(overflow), 1);

      // Reset in the middle of a window. The inputs on the reset edge are ignored.
      send(7); send(9);
      rst = 1'b1; in_valid = 1'b1; in_data = 8'd99; out_ready = 1'b1;
      tick();
      rst = 1'b0; in_valid = 1'b0;
      check("mid_rst_lvl", int'(level), 0);
      check("mid_rst_ovf", int'(overflow), 0);
      check("mid_rst_valid", int'(out_valid), 0);
      out_ready = 1'b0;
      send(1); send(2); send(3);
      check("mid_nv3", int'(out_valid), 0);
      send(4);
      check("mid_out", int'(out_data), exp_win(1, 2, 3, 4));
      check("mid_lvl", int'(level), 1);

      // A push into a full FIFO with a simultaneous pop is accepted
      do_reset();
      for (int i = 1; i <= 20; i++) begin
         out_ready = (i == 20);
         send(i);
      end
      out_ready = 1'b0;
      check("fullpp_lvl", int'(level), 4);
      check("fullpp_ovf", int'(overflow), 0);
      out_ready = 1'b1;
      for (int k = 1; k < 5; k++) begin
         check($sformatf("fullpp_ord%0d", k), int'(out_data),
               exp_win(4*k + 1, 4*k + 2, 4*k + 3, 4*k + 4));
         idle();
      end
      check("fullpp_empty", int'(level), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
